// File: rtl/uart_tx_fifo_if.sv
// Byte-write side of the buffered UART transmitter: write strobe, data byte
// and the FIFO status flags returned to the writer.
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] data_send;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (
        output wr_en,
        output data_send,
        input  full,
        input  empty,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  data_send,
        output full,
        output empty,
        output overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO_DEPTH-entry byte FIFO feeding an 8-bit
// LSB-first serializer (start, 8 data, stop; idle high).
// Optional build macro UART_TX_PARITY_EN inserts one even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 8N1).
// tx is a registered copy of the serializer's bit for the current state, so
// the line trails the state register by exactly one clock.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   bus,
    output logic            tx,
    output logic            tx_busy,
    output logic            byte_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST_C = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;

    state_t           state_r;
    logic [15:0]      baud_r;
    logic [2:0]       bit_r;
    logic [7:0]       shift_r;
`ifdef UART_TX_PARITY_EN
    logic             parity_r;
`endif
    logic             tx_r;
    logic             busy_r;
    logic             done_r;

    logic             push_s;
    logic             pop_s;
    logic             baud_last_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Push/pop decisions and next occupancy; full is the pre-pop value, so a
    // write while full is dropped even when the serializer pops on that edge.
    always_comb begin
        push_s      = bus.wr_en && !full_r;
        pop_s       = (state_r == IDLE) && !empty_r;
        baud_last_s = (baud_r == BAUD_LAST_C);
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.data_send;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    // Serializer FSM with registered line, busy and end-of-stop pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            baud_r   <= 16'd0;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Busy trails the state by one clock like tx, so it drops only
            // after the last stop bit has actually left the line.
            busy_r <= (state_r != IDLE) || (count_r != {CNT_W{1'b0}}) || push_s;
            case (state_r)
                IDLE: begin
                    tx_r   <= 1'b1;
                    baud_r <= 16'd0;
                    bit_r  <= 3'd0;
                    if (pop_s) begin
                        shift_r  <= mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(mem_r[rd_ptr_r]);
`endif
                        state_r  <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    tx_r <= 1'b0;
                    if (baud_last_s) begin
                        baud_r  <= 16'd0;
                        bit_r   <= 3'd0;
                        state_r <= DATA;
                    end else begin
                        baud_r <= baud_r + 16'd1;
                    end
                end
                DATA: begin
                    tx_r <= shift_r[0];
                    if (baud_last_s) begin
                        baud_r  <= 16'd0;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
                            bit_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_r <= parity_r;
                    if (baud_last_s) begin
                        baud_r  <= 16'd0;
                        state_r <= STOP;
                    end else begin
                        baud_r <= baud_r + 16'd1;
                    end
                end
`endif
                STOP: begin
                    tx_r <= 1'b1;
                    if (baud_last_s) begin
                        baud_r  <= 16'd0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        baud_r <= baud_r + 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    baud_r  <= 16'd0;
                    bit_r   <= 3'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign byte_done    = done_r;
    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.overflow = overflow_r;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, byte-buffer entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 wr_en  input  1  write strobe, one byte per high cycle.
REQ-006 data_send  input  8  byte written when wr_en is high.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 tx_busy  output  1  high while any byte is buffered or a frame is on the line.
REQ-009 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 empty  output  1  FIFO holds zero bytes.
REQ-011 byte_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-012 overflow  output  1  sticky flag, set by a write while full.

Function
REQ-013 Write rule: wr_en=1 and full=0 at an edge stores data_send at the tail; the write pointer wraps modulo FIFO_DEPTH.
REQ-014 Write rule when full: wr_en=1 with full=1 discards the byte, leaves FIFO contents unchanged, and sets overflow.
REQ-015 Full is sampled before any same-cycle pop: a write while full is dropped even if a pop occurs on that edge.
REQ-016 Occupancy count: held with log2(FIFO_DEPTH)+1 bits; a simultaneous push and pop on a non-full FIFO leaves the count unchanged.
REQ-017 Serializer states: IDLE, START, DATA, PARITY (present only per REQ-028), STOP.
REQ-018 IDLE: tx=1; if empty=0, pop the head byte into the shift register and enter START on the same edge.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-020 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles; after bit 7 enter PARITY or STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles; on the final cycle pulse byte_done, then return to IDLE.
REQ-022 Back-to-back frames: with the FIFO non-empty, the next start bit begins one clk after STOP ends (a single idle cycle).
REQ-023 Latency: a byte accepted into an empty FIFO while IDLE drives tx low starting on the second rising edge after the accepting edge.
REQ-024 tx is registered and glitch-free.
REQ-025 tx_busy = (state != IDLE) OR (empty = 0); it falls only after the last byte's stop bit completes.

Reset
REQ-026 reset=0: state=IDLE; pointers and count cleared; tx=1; tx_busy=0; full=0; empty=1; byte_done=0; overflow=0; bit and baud counters cleared.
REQ-027 Reset during an active frame aborts it immediately: tx returns high asynchronously and all buffered bytes are lost.

Configuration
REQ-028 Macro UART_TX_PARITY_EN: when defined, PARITY sends one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving an 11-bit frame; when undefined, the PARITY state and logic are absent and the frame is 10 bits (8N1).

Verification
REQ-029 The bench SHALL cover the following directed scenarios, each run with CLKS_PER_BIT=4:
- Reset with wr_en=0 -> tx=1, empty=1, tx_busy=0, overflow=0.
- Single write 0xA5 into an empty FIFO -> tx low 2 edges after accept; bits 1,0,1,0,0,1,0,1 follow (plus parity 0 if enabled); stop bit high; one byte_done pulse; tx_busy falls after the stop bit; frame is 40 clk (44 with parity).
- Write 0x01, 0x02, 0x03 on consecutive cycles -> three frames, each separated by exactly one idle cycle; three byte_done pulses; tx_busy stays high throughout.
- Write FIFO_DEPTH+2 bytes, one per cycle, starting with the serializer idle -> first byte popped, next FIFO_DEPTH bytes stored, full=1, last byte dropped, overflow=1; exactly FIFO_DEPTH+1 frames are transmitted, in order.
- Assert reset mid-DATA of 0xFF while 3 bytes are queued -> tx=1 immediately, empty=1, no further frames after release.
- With UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1, frame 44 clk.
